// File: rtl/tinyjambu_perm_core.sv
// Keyed TinyJAMBU-128 permutation engine: 32 NLFSR steps per clock.
// Runs P_SHORT_STEPS or P_LONG_STEPS steps per start and pulses done when the result is final.
module tinyjambu_perm_core #(
   parameter int P_SHORT_STEPS = 640,
   parameter int P_LONG_STEPS  = 1024
) (
   input  logic         ACLK,
   input  logic         ARESETN,
   input  logic         start,
   input  logic         round_sel,
   input  logic [127:0] key_in,
   input  logic [127:0] state_in,
   output logic [127:0] state_out,
   output logic         busy,
   output logic         done
);

   typedef enum logic {IDLE, RUN} fsm_t;

   localparam logic [5:0] TGT_SHORT = 6'(P_SHORT_STEPS / 32);
   localparam logic [5:0] TGT_LONG  = 6'(P_LONG_STEPS / 32);

   fsm_t         fsm;
   logic [127:0] key_r;
   logic [5:0]   cnt;
   logic [5:0]   target;

   logic [31:0]  w0, w1, w2, w3, kw;
   logic [31:0]  t1, t2, t3, t4, fb;
   logic [5:0]   cnt_nxt;

   // Word-parallel form of 32 bit-serial steps; fb bit j only depends on bits that
   // have not yet been overwritten by earlier feedback bits of the same block.
   always_comb begin
      w0 = state_out[31:0];
      w1 = state_out[63:32];
      w2 = state_out[95:64];
      w3 = state_out[127:96];
      kw = key_r[{cnt[1:0], 5'b0} +: 32];
      t1 = (w1 >> 15) | (w2 << 17);
      t2 = (w2 >> 6)  | (w3 << 26);
      t3 = (w2 >> 21) | (w3 << 11);
      t4 = (w2 >> 27) | (w3 << 5);
      fb = w0 ^ t1 ^ ~(t2 & t3) ^ t4 ^ kw;
      cnt_nxt = cnt + 6'd1;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         fsm       <= IDLE;
         state_out <= '0;
         key_r     <= '0;
         cnt       <= '0;
         target    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_out <= state_in;
                  key_r     <= key_in;
                  target    <= round_sel ? TGT_LONG : TGT_SHORT;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  fsm       <= RUN;
               end
            end
            RUN: begin
               state_out <= {fb, w3, w2, w1};
               cnt       <= cnt_nxt;
               if (cnt_nxt == target) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  fsm  <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tinyjambu_perm_core.sv
// Scoreboard bench for tinyjambu_perm_core against a bit-serial TinyJAMBU reference model.
module tb_tinyjambu_perm_core;

   logic         ACLK = 1'b0;
   logic         ARESETN = 1'b0;
   logic         start = 1'b0;
   logic         round_sel = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] state_in = '0;
   logic [127:0] state_out;
   logic         busy, done;

   tinyjambu_perm_core dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .round_sel(round_sel),
      .key_in(key_in), .state_in(state_in), .state_out(state_out),
      .busy(busy), .done(done)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [127:0] res;
      int           due;
      int           tgt;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   blen = 0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: one bit per step, feedback taps s0, s47, s70, s85, s91.
   function automatic logic [127:0] perm(input logic [127:0] k, input logic [127:0] s_in, input int steps);
      logic [127:0] s;
      logic         fb;
      s = s_in;
      for (int i = 0; i < steps; i++) begin
         fb = s[0] ^ s[47] ^ ~(s[70] & s[85]) ^ s[91] ^ k[i & 127];
         s  = {fb, s[127:1]};
      end
      return s;
   endfunction

   // Drive a start that the DUT will accept; returns 1 time unit after the sampling edge.
   task automatic start_run(input logic [127:0] k, input logic [127:0] s, input logic rs);
      exp_t x;
      int   steps;
      key_in = k; state_in = s; round_sel = rs; start = 1'b1;
      @(posedge ACLK); #1;
      steps = rs ? 1024 : 640;
      x.res = perm(k, s, steps);
      x.tgt = steps / 32;
      x.due = cyc + x.tgt;
      q.push_back(x);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge ACLK);
      chk("drain_timeout", 128'(q.size()), 128'd0);
   endtask

   always @(negedge ACLK) begin
      if (busy) blen++;
      if (done) begin
         chk("done_and_busy", {127'd0, busy}, 128'd0);
         if (q.size() == 0) chk("spurious_done", 128'd1, 128'd0);
         else begin
            e = q.pop_front();
            chk("result", state_out, e.res);
            chk("latency", 128'(cyc), 128'(e.due));
            chk("busy_len", 128'(blen), 128'(e.tgt));
         end
      end
      if (!busy) blen = 0;
   end

   logic [127:0] rk, rs0;

   initial begin
      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_state", state_out, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_done", {127'd0, done}, 128'd0);
      ARESETN = 1'b1;
      @(posedge ACLK); #1;

      // zero vector
      start_run('0, '0, 1'b0);
      chk("busy_rise", {127'd0, busy}, 128'd1);
      @(posedge ACLK); #1;
      chk("zero_blk1", state_out, {32'hFFFFFFFF, 96'd0});
      wait_drain();

      // key cancellation
      start_run({96'd0, 32'hFFFFFFFF}, '0, 1'b0);
      @(posedge ACLK); #1;
      chk("keycancel_blk1", state_out, 128'd0);
      wait_drain();

      // long permutation, random
      rk  = {$urandom, $urandom, $urandom, $urandom};
      rs0 = {$urandom, $urandom, $urandom, $urandom};
      start_run(rk, rs0, 1'b1);
      wait_drain();

      // start while busy plus input changes mid-run
      start_run(rk, rs0, 1'b0);
      repeat (4) @(posedge ACLK);
      #1;
      key_in = ~rk; state_in = ~rs0; round_sel = 1'b1; start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      wait_drain();
      repeat (3) @(negedge ACLK);
      chk("no_restart_busy", {127'd0, busy}, 128'd0);

      // reset mid-run
      start_run(rs0, rk, 1'b0);
      repeat (9) @(posedge ACLK);
      #1;
      ARESETN = 1'b0;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      chk("midrst_busy", {127'd0, busy}, 128'd0);
      chk("midrst_done", {127'd0, done}, 128'd0);
      chk("midrst_state", state_out, 128'd0);
      q.delete();
      repeat (30) @(posedge ACLK);
      #1;
      start_run(rs0, rk, 1'b0);
      wait_drain();

      // back-to-back: second start in the done cycle
      start_run(rk, ~rs0, 1'b0);
      repeat (20) @(posedge ACLK);
      #1;
      chk("b2b_done_high", {127'd0, done}, 128'd1);
      start_run(~rk, rs0, 1'b1);
      chk("b2b_busy_next", {127'd0, busy}, 128'd1);
      wait_drain();

      repeat (3) @(posedge ACLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
